// File: rtl/fp_mult_feeder_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_mult_feeder_if : operand-in / result-out handshake bundle       |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface fp_mult_feeder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [3:0]            out_flags;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, out_flags
  );
endinterface
`default_nettype wire

// File: rtl/fp_mult_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fp_mult_feeder : operand FIFO + IEEE special-case fixup for fp_mult|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fp_mult_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  fp_mult_feeder_if.slave             bus,
  output logic [DATA_WIDTH-1:0]       mul_a,
  output logic [DATA_WIDTH-1:0]       mul_b,
  input  logic [DATA_WIDTH-1:0]       mul_p,
  output logic [$clog2(FIFO_DEPTH):0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_a_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_a_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_b_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_b_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [3:0]            out_flags_q, out_flags_d;

  logic                  push, pop, empty;
  logic [DATA_WIDTH-1:0] res_data;
  logic [3:0]            res_flags;
  logic [7:0]            ea, eb;
  logic                  a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sg;
  logic [9:0]            exp_sum;
  logic signed [10:0]    exp_unb;

  assign empty        = (count_q == '0);
  assign bus.in_ready = !rst && (count_q < CW'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = !empty && (!out_valid_q || bus.out_ready);

  assign mul_a = empty ? '0 : mem_a_q[rd_ptr_q];
  assign mul_b = empty ? '0 : mem_b_q[rd_ptr_q];

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_flags = out_flags_q;
  assign count         = count_q;

  // Classify the head pair and override the raw multiplier product.
  always_comb begin
    ea      = mul_a[30:23];
    eb      = mul_b[30:23];
    a_nan   = (ea == 8'hFF) && (mul_a[22:0] != '0);
    b_nan   = (eb == 8'hFF) && (mul_b[22:0] != '0);
    a_inf   = (ea == 8'hFF) && (mul_a[22:0] == '0);
    b_inf   = (eb == 8'hFF) && (mul_b[22:0] == '0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    sg      = mul_a[31] ^ mul_b[31];
    exp_sum = {2'b00, ea} + {2'b00, eb};
    exp_unb = $signed({1'b0, exp_sum}) - 11'sd127;

    res_data  = mul_p;
    res_flags = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      res_data  = 32'h7FC0_0000;
      res_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      res_data  = {sg, 8'hFF, 23'd0};
      res_flags = 4'b0100;
    end else if (a_zero || b_zero) begin
      res_data  = {sg, 31'd0};
      res_flags = 4'b0010;
    end else if ((exp_unb >= 11'sd255) ||
                 ((exp_unb == 11'sd254) && (mul_p[30:23] != 8'hFE))) begin
      // At the top boundary a normalisation carry pushes the product out of range.
      res_data  = {sg, 8'hFF, 23'd0};
      res_flags = 4'b0101;
    end else if ((exp_unb < 11'sd0) ||
                 ((exp_unb == 11'sd0) && (mul_p[30:23] != 8'h01))) begin
      res_data  = {sg, 31'd0};
      res_flags = 4'b0011;
    end
  end

  always_comb begin
    mem_a_d     = mem_a_q;
    mem_b_d     = mem_b_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_flags_d = out_flags_q;

    if (push) begin
      mem_a_d[wr_ptr_q] = bus.in_a;
      mem_b_d[wr_ptr_q] = bus.in_b;
      wr_ptr_d          = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      out_valid_d = 1'b1;
      out_data_d  = res_data;
      out_flags_d = res_flags;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_a_q     <= '{default: '0};
      mem_b_q     <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_flags_q <= '0;
    end else begin
      mem_a_q     <= mem_a_d;
      mem_b_q     <= mem_b_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_flags_q <= out_flags_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_fp_mult_feeder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fp_mult_feeder : scoreboard bench with fp_mult behavioural model|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_fp_mult_feeder;
  logic        clk;
  logic        rst;
  logic [31:0] mul_a, mul_b, mul_p;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  logic [35:0] exp_q [$];

  fp_mult_feeder_if #(.DATA_WIDTH(32)) bus ();

  fp_mult_feeder #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncating single-precision multiplier, standing in for fp_mult.
  function automatic logic [31:0] mult_model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned prod;
    int              bump, e;
    logic [22:0]     mant;
    prod = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
    bump = int'((prod >> 47) & 1);
    mant = (bump != 0) ? 23'(prod >> 24) : 23'(prod >> 23);
    e    = int'(a[30:23]) + int'(b[30:23]) - 127 + bump;
    return {a[31] ^ b[31], e[7:0], mant};
  endfunction

  assign mul_p = mult_model(mul_a, mul_b);

  // Reference result {flags, data} from the IEEE rules and the final biased exponent.
  function automatic logic [35:0] ref_result(input logic [31:0] a, input logic [31:0] b);
    bit  an, bn, ai, bi, az, bz, s;
    int  final_e;
    an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    az = (a[30:23] == 8'h00);
    bz = (b[30:23] == 8'h00);
    s  = a[31] ^ b[31];
    if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
    if (ai || bi)                             return {4'b0100, s, 8'hFF, 23'd0};
    if (az || bz)                             return {4'b0010, s, 31'd0};
    final_e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if ((real'(1 + a[22:0] / 8388608.0) * real'(1 + b[22:0] / 8388608.0)) >= 2.0)
      final_e = final_e + 1;
    if (final_e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (final_e <= 0)   return {4'b0011, s, 31'd0};
    return {4'b0000, mult_model(a, b)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0]  e;
    logic [22:0] m;
    int          sel;
    sel = $urandom_range(0, 9);
    m   = 23'($urandom);
    case (sel)
      0:       begin e = 8'h00; if ($urandom_range(0, 1) == 0) m = '0; end
      1:       begin e = 8'hFF; if ($urandom_range(0, 1) == 0) m = '0; end
      2:       e = 8'($urandom_range(1, 40));
      3:       e = 8'($urandom_range(200, 254));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom), e, m};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns at posedge+1; expectation is queued only if the pair was accepted.
  task automatic drive_pair(input logic [31:0] a, input logic [31:0] b,
                            input logic [35:0] e, output bit acc);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    @(negedge clk);
    acc = bus.in_ready;
    if (acc) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout remaining=%0d expected=0", exp_q.size());
    end
  endtask

  // Monitor: every output handshake pops the oldest expectation.
  always @(negedge clk) begin
    logic [35:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%h expected=none", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("result_data", bus.out_data, e[31:0]);
        chk("result_flags", {28'd0, bus.out_flags}, {28'd0, e[35:32]});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_a [10] = '{32'h3FC00000, 32'h7FC00001, 32'h7F800000, 32'hFF800000,
                              32'h7F000000, 32'h00800000, 32'h80000000, 32'h7F400000,
                              32'h00C00000, 32'h00800000};
  logic [31:0] dir_b [10] = '{32'h40000000, 32'h3F800000, 32'h00000000, 32'h40000000,
                              32'h7F000000, 32'h00800000, 32'h3F800000, 32'h3FC00000,
                              32'h3F400000, 32'h3F000000};
  logic [35:0] dir_e [10] = '{{4'b0000, 32'h40400000}, {4'b1000, 32'h7FC00000},
                              {4'b1000, 32'h7FC00000}, {4'b0100, 32'hFF800000},
                              {4'b0101, 32'h7F800000}, {4'b0011, 32'h00000000},
                              {4'b0010, 32'h80000000}, {4'b0101, 32'h7F800000},
                              {4'b0000, 32'h00900000}, {4'b0011, 32'h00000000}};

  initial begin
    bit          acc;
    int          n_acc;
    logic [31:0] ra, rb;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_count", {29'd0, count}, 32'd0);
    chk("reset_out_data", bus.out_data, 32'd0);
    chk("reset_out_flags", {28'd0, bus.out_flags}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset_mul_a", mul_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_reset", {31'd0, bus.in_ready}, 32'd1);

    // Directed vectors; the first also checks two-cycle latency.
    bus.out_ready = 1'b1;
    drive_pair(dir_a[0], dir_b[0], dir_e[0], acc);
    @(negedge clk);
    chk("latency_one_cycle_valid", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("latency_two_cycle_valid", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    for (int i = 1; i < 10; i++) drive_pair(dir_a[i], dir_b[i], dir_e[i], acc);
    wait_drain();

    // Back-pressure: four in the FIFO plus one held in the output register.
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      drive_pair(ra, rb, ref_result(ra, rb), acc);
      if (acc) n_acc++;
    end
    chk("full_accepted", n_acc, 32'd5);
    chk("full_count", {29'd0, count}, 32'd4);
    chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("full_drain_valid", {31'd0, bus.out_valid}, 32'd1);
    end
    wait_drain();

    // Steady state at occupancy two with a push and a pop every cycle.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      drive_pair(ra, rb, ref_result(ra, rb), acc);
    end
    chk("steady_start_count", {29'd0, count}, 32'd2);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      drive_pair(ra, rb, ref_result(ra, rb), acc);
      chk("steady_count", {29'd0, count}, 32'd2);
    end
    wait_drain();

    // Asynchronous reset with work in flight.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      drive_pair(ra, rb, ref_result(ra, rb), acc);
    end
    chk("pre_reset_count", {29'd0, count}, 32'd3);
    chk("pre_reset_out_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_reset_count", {29'd0, count}, 32'd0);
    chk("async_reset_out_data", bus.out_data, 32'd0);
    chk("async_reset_out_flags", {28'd0, bus.out_flags}, 32'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_count", {29'd0, count}, 32'd0);
    chk("post_reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.out_ready = 1'b1;
    drive_pair(dir_a[0], dir_b[0], dir_e[0], acc);
    wait_drain();

    // Randomised traffic with random back-pressure.
    for (int i = 0; i < 300; i++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) != 0) begin
        ra = rand_fp();
        rb = rand_fp();
        drive_pair(ra, rb, ref_result(ra, rb), acc);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.out_ready = 1'b1;
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fp_mult_feeder.md
# fp_mult_feeder

Streaming operand stage that sits directly upstream of the single-precision multiplier `fp_mult`. It buffers operand pairs in a small FIFO, drives the head pair onto the multiplier's `data_1`/`data_2` inputs, and samples `data_prod` into a registered output with valid/ready handshake. The multiplier itself handles no IEEE special cases, so this block also classifies operands and results and overrides NaN, infinity, zero/denormal, overflow and underflow cases with correct encodings and flags.

## Interface
- `DATA_WIDTH`, 32: operand/result width; fixed at 32 to match `fp_mult`.
- `FIFO_DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: FIFO can accept; `count < FIFO_DEPTH` and not in reset.
- `in_a`, `in_b` in 32: operand pair, IEEE-754 single.
- `mul_a`, `mul_b` out 32: to `fp_mult` `data_1`/`data_2`; FIFO head, 0 when empty.
- `mul_p` in 32: from `fp_mult` `data_prod`.
- `out_valid` out 1: result register holds a result.
- `out_ready` in 1: consumer accepts.
- `out_data` out 32: final product.
- `out_flags` out 4: {nan, inf, zero, range}; range = overflow or underflow forced the result.
- `count` out log2(FIFO_DEPTH)+1: FIFO occupancy.

## Operation
- Push when `in_valid && in_ready`; write pointer increments, wraps modulo `FIFO_DEPTH`.
- Load (pop) when FIFO non-empty and (`!out_valid || out_ready`); head result written to output register, read pointer increments/wraps, `out_valid` set.
- `out_valid && out_ready` with no load: `out_valid` clears; `out_data`/`out_flags` hold.
- Push and pop same cycle: `count` unchanged. Full FIFO never accepts a push even if popping that cycle (no bypass).
- Result selection for head pair (a, b), ea/eb = exponent fields, s = ea+eb (10-bit), e = s−127 (signed), sg = a[31]^b[31], priority order:
  1. either NaN (exp 0xFF, mant≠0), or inf×(zero/denormal) → 0x7FC00000, flags 4'b1000.
  2. either inf → {sg, 0xFF, 0}, flags 4'b0100.
  3. either exp==0 (zero or denormal, flushed) → {sg, 31'b0}, flags 4'b0010.
  4. e ≥ 255, or e == 254 and `mul_p[30:23]` ≠ 0xFE → {sg, 0xFF, 0}, flags 4'b0101.
  5. e < 0, or e == 0 and `mul_p[30:23]` ≠ 0x01 → {sg, 31'b0}, flags 4'b0011.
  6. otherwise `mul_p` unchanged, flags 0.
- No rounding beyond what `fp_mult` produces (truncation).

## Timing
- Reset: pointers, `count` = 0; `out_valid` = 0; `out_data` = 0; `out_flags` = 0; `in_ready` = 0 while `rst` high, 1 from first cycle after release.
- `mul_a`/`mul_b`/`mul_p` path combinational; result sampled at the pop edge.
- Latency, empty pipe: pair pushed at edge N is head after N; `out_valid` high after edge N+1 (2 cycles input to output).
- Throughput: one result per cycle with `out_ready` held high.
- Reset mid-operation: FIFO contents and pending result discarded immediately (async); no partial outputs after release.

## Test plan
- 0x3FC00000 × 0x40000000 (1.5×2.0), `out_ready`=1 → `out_data` 0x40400000, flags 0, `out_valid` two cycles after push.
- 0x7FC00001 × 0x3F800000, then 0x7F800000 × 0x00000000 → both 0x7FC00000, flags 4'b1000; 0xFF800000 × 0x40000000 → 0xFF800000, flags 4'b0100.
- 0x7F000000 × 0x7F000000 → 0x7F800000, flags 4'b0101; 0x00800000 × 0x00800000 → 0x00000000, flags 4'b0011; 0x80000000 × 0x3F800000 → 0x80000000, flags 4'b0010.
- `out_ready`=0, push 6 pairs: 4 enter FIFO plus 1 in output register, `in_ready` low at `count`=4; raise `out_ready` → all 5 results in push order, one per cycle, pointers wrap correctly.
- Push and pop every cycle for 20 cycles with `count`=2 → `count` stays 2, results in order.
- Assert `rst` asynchronously with `count`=3 and `out_valid`=1 → `out_valid`, `count`, `out_data`, `out_flags` 0 immediately; next pushed pair is the first result out.
